// File: rtl/pmp_entry_sequencer_pkg.sv
// Shared types and constants for the PMP entry sequencer:
// address-matching modes, the per-entry configuration byte layout,
// CSR numbers and the WARL legalisation of a written configuration byte.
package pmp_entry_sequencer_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        TOR   = 2'd1,
        NA4   = 2'd2,
        NAPOT = 2'd3
    } pmp_mode_e;

    typedef struct packed {
        logic       l;
        logic [1:0] rsvd;
        pmp_mode_e  a;
        logic       x;
        logic       w;
        logic       r;
    } pmp_cfg_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } seq_state_e;

    localparam logic [11:0] PMPCFG0_ADDR  = 12'h3A0;
    localparam logic [11:0] PMPADDR0_ADDR = 12'h3B0;
    localparam logic [29:0] MASK_ALL_ONES = 30'h3FFF_FFFF;

    // Legalise a written cfg byte: W without R is not allowed, bits 6:5 read as zero.
    function automatic pmp_cfg_t cfg_warl(input logic [7:0] b);
        pmp_cfg_t c;
        c.l    = b[7];
        c.rsvd = b[6:5] & 2'b00;
        c.a    = pmp_mode_e'(b[4:3]);
        c.x    = b[2];
        c.w    = b[1] & b[0];
        c.r    = b[0];
        return c;
    endfunction

endpackage

// File: rtl/pmp_entry_sequencer_if.sv
// CSR write/read port of the PMP entry sequencer.
// master = CSR requester, slave = sequencer.
interface pmp_entry_sequencer_if;
    logic        csr_valid_i;
    logic        csr_ready_o;
    logic [11:0] csr_addr_i;
    logic [31:0] csr_wdata_i;
    logic [31:0] csr_rdata_o;

    modport master (
        output csr_valid_i,
        output csr_addr_i,
        output csr_wdata_i,
        input  csr_ready_o,
        input  csr_rdata_o
    );

    modport slave (
        input  csr_valid_i,
        input  csr_addr_i,
        input  csr_wdata_i,
        output csr_ready_o,
        output csr_rdata_o
    );
endinterface

// File: rtl/pmp_entry_sequencer_napot.sv
// NAPOT range decoder: turns a pmpaddr word address into a match mask
// and the masked match base. t = number of trailing ones; mask keeps only
// bits above position t, so t >= 29 yields an all-zero mask.
module pmp_entry_sequencer_napot (
    input  logic [29:0] addr_i,
    output logic [29:0] mask_o,
    output logic [29:0] match_address_o
);

    logic [4:0] ones_s;
    logic       run_s;

    // Count trailing ones and build the mask from that count.
    always_comb begin
        ones_s = 5'd0;
        run_s  = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (run_s && addr_i[i]) begin
                ones_s = ones_s + 5'd1;
            end else begin
                run_s = 1'b0;
            end
        end
        mask_o = 30'h0;
        for (int i = 0; i < 30; i++) begin
            mask_o[i] = (5'(i) > ones_s);
        end
        match_address_o = addr_i & mask_o;
    end

endmodule

// File: rtl/pmp_entry_sequencer.sv
// PMP entry sequencer: holds pmpcfg/pmpaddr state behind the CSR write port,
// re-decodes dirty entries one per cycle through a single NAPOT decoder and
// publishes the cached match table. The table is stale while table_valid_o is low.
// Optional feature macro: PMP_CSR_READ_EN (combinational CSR read-back).
module pmp_entry_sequencer
    import pmp_entry_sequencer_pkg::*;
#(
    parameter int ENTRIES = 8
) (
    input  logic                    cpu_clock_i,
    input  logic                    cpu_reset_i,
    pmp_entry_sequencer_if.slave    csr_if,
    output logic                    table_valid_o,
    output logic [2*ENTRIES-1:0]    entry_mode_o,
    output logic [4*ENTRIES-1:0]    entry_perm_o,
    output logic [30*ENTRIES-1:0]   entry_mask_o,
    output logic [30*ENTRIES-1:0]   entry_base_o
);

    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    // Configuration state
    seq_state_e          state_q, state_d;
    logic [ENTRIES-1:0]  dirty_q, dirty_d;
    pmp_cfg_t            cfg_q   [ENTRIES];
    pmp_cfg_t            cfg_d   [ENTRIES];
    logic [29:0]         addr_q  [ENTRIES];
    logic [29:0]         addr_d  [ENTRIES];

    // Published table
    logic [1:0]          mode_q  [ENTRIES];
    logic [3:0]          perm_q  [ENTRIES];
    logic [29:0]         mask_q  [ENTRIES];
    logic [29:0]         base_q  [ENTRIES];

    logic                csr_accept_s;
    logic                scan_active_s;
    logic [IDX_W-1:0]    scan_idx_s;
    logic                scan_found_s;
    logic [ENTRIES:0]    tor_lock_s;
    logic [ENTRIES-1:0]  addr_locked_s;
    logic [29:0]         dec_addr_s;
    logic [29:0]         dec_mask_s;
    logic [29:0]         dec_base_s;
    logic                unused_bits_s;

    assign csr_accept_s          = csr_if.csr_valid_i && (state_q == IDLE);
    assign scan_active_s         = (state_q == SCAN) && (|dirty_q);
    assign csr_if.csr_ready_o    = (state_q == IDLE);
    assign table_valid_o         = (state_q == IDLE);

    // An address is frozen by its own lock or by a locked TOR entry right above it.
    always_comb begin
        tor_lock_s = {(ENTRIES+1){1'b0}};
        for (int k = 0; k < ENTRIES; k++) begin
            tor_lock_s[k] = cfg_q[k].l && (cfg_q[k].a == TOR);
        end
        addr_locked_s = {ENTRIES{1'b0}};
        for (int k = 0; k < ENTRIES; k++) begin
            addr_locked_s[k] = cfg_q[k].l | tor_lock_s[k+1];
        end
    end

    // Priority encoder: lowest dirty entry is scanned first.
    always_comb begin
        scan_idx_s   = {IDX_W{1'b0}};
        scan_found_s = 1'b0;
        for (int k = 0; k < ENTRIES; k++) begin
            if (dirty_q[k] && !scan_found_s) begin
                scan_idx_s   = IDX_W'(k);
                scan_found_s = 1'b1;
            end else begin
                scan_found_s = scan_found_s;
            end
        end
    end

    // CSR write decode and dirty tracking; a scan step retires one dirty bit.
    always_comb begin
        cfg_d   = cfg_q;
        addr_d  = addr_q;
        dirty_d = dirty_q;
        if (csr_accept_s) begin
            for (int k = 0; k < ENTRIES; k++) begin
                if ((csr_if.csr_addr_i == (PMPADDR0_ADDR + 12'(k))) && !addr_locked_s[k]) begin
                    addr_d[k]  = csr_if.csr_wdata_i[29:0];
                    dirty_d[k] = 1'b1;
                end else if ((csr_if.csr_addr_i == (PMPCFG0_ADDR + 12'(k / 4))) && !cfg_q[k].l) begin
                    cfg_d[k]   = cfg_warl(csr_if.csr_wdata_i[8*(k%4) +: 8]);
                    dirty_d[k] = 1'b1;
                end else begin
                    dirty_d[k] = dirty_q[k];
                end
            end
        end else if (scan_active_s) begin
            dirty_d[scan_idx_s] = 1'b0;
        end else begin
            dirty_d = dirty_q;
        end
    end

    // Next state: scan while anything is dirty, otherwise accept CSR writes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (|dirty_d) begin
                    state_d = SCAN;
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                if (|dirty_d) begin
                    state_d = SCAN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    // Configuration registers, dirty set and FSM state.
    always_ff @(posedge cpu_clock_i) begin
        if (cpu_reset_i) begin
            state_q <= SCAN;
            dirty_q <= {ENTRIES{1'b1}};
            for (int k = 0; k < ENTRIES; k++) begin
                cfg_q[k]  <= pmp_cfg_t'(8'h00);
                addr_q[k] <= 30'h0;
            end
        end else begin
            state_q <= state_d;
            dirty_q <= dirty_d;
            cfg_q   <= cfg_d;
            addr_q  <= addr_d;
        end
    end

    assign dec_addr_s = addr_q[scan_idx_s];

    pmp_entry_sequencer_napot u_napot (
        .addr_i          (dec_addr_s),
        .mask_o          (dec_mask_s),
        .match_address_o (dec_base_s)
    );

    // Table write for the entry under scan; non-NAPOT modes match the raw address.
    always_ff @(posedge cpu_clock_i) begin
        if (cpu_reset_i) begin
            for (int k = 0; k < ENTRIES; k++) begin
                mode_q[k] <= 2'b00;
                perm_q[k] <= 4'h0;
                mask_q[k] <= 30'h0;
                base_q[k] <= 30'h0;
            end
        end else if (scan_active_s) begin
            mode_q[scan_idx_s] <= cfg_q[scan_idx_s].a;
            perm_q[scan_idx_s] <= {cfg_q[scan_idx_s].l, cfg_q[scan_idx_s].x,
                                   cfg_q[scan_idx_s].w, cfg_q[scan_idx_s].r};
            if (cfg_q[scan_idx_s].a == NAPOT) begin
                mask_q[scan_idx_s] <= dec_mask_s;
                base_q[scan_idx_s] <= dec_base_s;
            end else begin
                mask_q[scan_idx_s] <= MASK_ALL_ONES;
                base_q[scan_idx_s] <= addr_q[scan_idx_s];
            end
        end
    end

    // Flatten the table onto the checker-facing buses.
    always_comb begin
        entry_mode_o = {(2*ENTRIES){1'b0}};
        entry_perm_o = {(4*ENTRIES){1'b0}};
        entry_mask_o = {(30*ENTRIES){1'b0}};
        entry_base_o = {(30*ENTRIES){1'b0}};
        for (int k = 0; k < ENTRIES; k++) begin
            entry_mode_o[2*k +: 2]   = mode_q[k];
            entry_perm_o[4*k +: 4]   = perm_q[k];
            entry_mask_o[30*k +: 30] = mask_q[k];
            entry_base_o[30*k +: 30] = base_q[k];
        end
    end

`ifdef PMP_CSR_READ_EN
    logic [31:0] rdata_s;

    // CSR read-back mux, valid in any FSM state.
    always_comb begin
        rdata_s = 32'h0;
        for (int k = 0; k < ENTRIES; k++) begin
            if (csr_if.csr_addr_i == (PMPADDR0_ADDR + 12'(k))) begin
                rdata_s = {2'b00, addr_q[k]};
            end else if (csr_if.csr_addr_i == (PMPCFG0_ADDR + 12'(k / 4))) begin
                rdata_s[8*(k%4) +: 8] = cfg_q[k];
            end else begin
                rdata_s = rdata_s;
            end
        end
    end

    assign csr_if.csr_rdata_o = rdata_s;
`else
    assign csr_if.csr_rdata_o = 32'h0;
`endif

    // Read-only and reserved bits that no logic consumes.
    always_comb begin
        unused_bits_s = ^csr_if.csr_wdata_i[31:30];
        for (int k = 0; k < ENTRIES; k++) begin
            unused_bits_s = unused_bits_s ^ (^cfg_q[k].rsvd);
        end
    end

endmodule

// File: tb/tb_pmp_entry_sequencer.sv
// Directed bench for pmp_entry_sequencer (8 entries).
// Define PMP_CSR_READ_EN to also check CSR read-back.
module tb_pmp_entry_sequencer;

    logic        clk;
    logic        rst;
    logic        table_valid;
    logic [15:0] entry_mode;
    logic [31:0] entry_perm;
    logic [239:0] entry_mask;
    logic [239:0] entry_base;

    int tests_run;
    int tests_failed;

    pmp_entry_sequencer_if csr_bus ();

    pmp_entry_sequencer #(.ENTRIES(8)) dut (
        .cpu_clock_i   (clk),
        .cpu_reset_i   (rst),
        .csr_if        (csr_bus),
        .table_valid_o (table_valid),
        .entry_mode_o  (entry_mode),
        .entry_perm_o  (entry_perm),
        .entry_mask_o  (entry_mask),
        .entry_base_o  (entry_base)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [1:0] mode_of(input int e);
        return entry_mode[2*e +: 2];
    endfunction
    function automatic logic [3:0] perm_of(input int e);
        return entry_perm[4*e +: 4];
    endfunction
    function automatic logic [29:0] mask_of(input int e);
        return entry_mask[30*e +: 30];
    endfunction
    function automatic logic [29:0] base_of(input int e);
        return entry_base[30*e +: 30];
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic do_write(input logic [11:0] a, input logic [31:0] d, output int stalls);
        csr_bus.csr_valid_i = 1'b1;
        csr_bus.csr_addr_i  = a;
        csr_bus.csr_wdata_i = d;
        stalls = 0;
        while (csr_bus.csr_ready_o !== 1'b1 && stalls < 64) begin
            stalls++;
            @(negedge clk);
        end
        if (stalls >= 64) begin
            tests_run++;
            tests_failed++;
            $display("FAIL write_timeout: addr %h never accepted after %0d cycles, required acceptance", a, stalls);
        end
        @(posedge clk);
        #1;
        csr_bus.csr_valid_i = 1'b0;
        @(negedge clk);
    endtask

    // Counts cycles with table_valid low, starting at the current negedge.
    task automatic count_low(output int n);
        n = 0;
        while (table_valid !== 1'b1 && n < 64) begin
            n++;
            @(negedge clk);
        end
        if (n >= 64) begin
            tests_run++;
            tests_failed++;
            $display("FAIL scan_timeout: table_valid still low after %0d cycles, required high", n);
        end
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        csr_bus.csr_valid_i = 1'b0;
        csr_bus.csr_addr_i  = 12'h000;
        csr_bus.csr_wdata_i = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (table_valid !== 1'b0 || csr_bus.csr_ready_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: valid=%b ready=%b, required 0/0", table_valid, csr_bus.csr_ready_o);
        end
        tests_run++;
        if (entry_mode !== 16'h0 || entry_perm !== 32'h0 || entry_mask !== 240'h0 || entry_base !== 240'h0) begin
            tests_failed++;
            $display("FAIL reset_table: mode=%h perm=%h, required all-zero table", entry_mode, entry_perm);
        end
        rst = 1'b0;
        count_low(n);
        tests_run++;
        if (n !== 8) begin
            tests_failed++;
            $display("FAIL reset_scan_len: %0d cycles low, required 8", n);
        end
        for (int e = 0; e < 8; e++) begin
            tests_run++;
            if (mode_of(e) !== 2'd0 || mask_of(e) !== 30'h3FFF_FFFF || base_of(e) !== 30'h0 || perm_of(e) !== 4'h0) begin
                tests_failed++;
                $display("FAIL reset_entry%0d: mode=%h mask=%h base=%h, required 0/3fffffff/0", e, mode_of(e), mask_of(e), base_of(e));
            end
        end
    endtask

    task automatic test_napot();
        int s, n;
        do_write(12'h3B2, 32'h0000_0FFF, s);
        count_low(n);
        tests_run++;
        if (n !== 1) begin tests_failed++; $display("FAIL napot_addr_scan: %0d, required 1", n); end
        tests_run++;
        if (mode_of(2) !== 2'd0 || base_of(2) !== 30'h0000_0FFF || mask_of(2) !== 30'h3FFF_FFFF) begin
            tests_failed++;
            $display("FAIL napot_off_entry2: mode=%h base=%h mask=%h, required 0/fff/3fffffff", mode_of(2), base_of(2), mask_of(2));
        end
        do_write(12'h3A0, 32'h0018_0000, s);
        count_low(n);
        tests_run++;
        if (n !== 4) begin tests_failed++; $display("FAIL napot_cfg_scan: %0d, required 4", n); end
        tests_run++;
        if (mode_of(2) !== 2'd3 || mask_of(2) !== 30'h3FFF_E000 || base_of(2) !== 30'h0 || perm_of(2) !== 4'h0) begin
            tests_failed++;
            $display("FAIL napot_entry2: mode=%h mask=%h base=%h perm=%h, required 3/3fffe000/0/0", mode_of(2), mask_of(2), base_of(2), perm_of(2));
        end
        do_write(12'h3B2, 32'h1FFF_FFFF, s);
        count_low(n);
        tests_run++;
        if (mask_of(2) !== 30'h0 || base_of(2) !== 30'h0) begin
            tests_failed++;
            $display("FAIL napot_t29: mask=%h base=%h, required 0/0", mask_of(2), base_of(2));
        end
        do_write(12'h3B2, 32'h0000_0FFF, s);
        count_low(n);
        tests_run++;
        if (mask_of(2) !== 30'h3FFF_E000) begin
            tests_failed++;
            $display("FAIL napot_restore: mask=%h, required 3fffe000", mask_of(2));
        end
    endtask

    task automatic test_lock_warl();
        int s, n;
        do_write(12'h3A0, 32'h0018_8200, s);
        count_low(n);
        tests_run++;
        if (n !== 4 || perm_of(1) !== 4'b1000 || mode_of(1) !== 2'd0 || mode_of(2) !== 2'd3) begin
            tests_failed++;
            $display("FAIL lock_entry1: scan=%0d perm1=%h mode1=%h mode2=%h, required 4/8/0/3", n, perm_of(1), mode_of(1), mode_of(2));
        end
        do_write(12'h3B1, 32'h0000_0123, s);
        count_low(n);
        tests_run++;
        if (n !== 0 || base_of(1) !== 30'h0) begin
            tests_failed++;
            $display("FAIL lock_addr1: scan=%0d base1=%h, required 0/0", n, base_of(1));
        end
        do_write(12'h3A0, 32'h0018_0361, s);
        count_low(n);
        tests_run++;
        if (n !== 3 || perm_of(1) !== 4'b1000 || perm_of(0) !== 4'b0001 || mode_of(0) !== 2'd0) begin
            tests_failed++;
            $display("FAIL lock_cfg_rewrite: scan=%0d perm1=%h perm0=%h mode0=%h, required 3/8/1/0", n, perm_of(1), perm_of(0), mode_of(0));
        end
`ifdef PMP_CSR_READ_EN
        csr_bus.csr_addr_i = 12'h3A0;
        #1;
        tests_run++;
        if (csr_bus.csr_rdata_o !== 32'h0018_8001) begin
            tests_failed++;
            $display("FAIL read_cfg0_t3: %h, required 00188001", csr_bus.csr_rdata_o);
        end
        @(negedge clk);
`endif
    endtask

    task automatic test_tor_lock();
        int s, n;
        do_write(12'h3A0, 32'h8800_0000, s);
        count_low(n);
        tests_run++;
        if (n !== 3 || mode_of(3) !== 2'd1 || perm_of(3) !== 4'b1000 || mode_of(2) !== 2'd0 || base_of(2) !== 30'h0000_0FFF) begin
            tests_failed++;
            $display("FAIL tor_cfg: scan=%0d mode3=%h perm3=%h mode2=%h base2=%h, required 3/1/8/0/fff", n, mode_of(3), perm_of(3), mode_of(2), base_of(2));
        end
        do_write(12'h3B2, 32'h0000_0005, s);
        count_low(n);
        tests_run++;
        if (n !== 0 || base_of(2) !== 30'h0000_0FFF) begin
            tests_failed++;
            $display("FAIL tor_addr2_locked: scan=%0d base2=%h, required 0/fff", n, base_of(2));
        end
        do_write(12'h300, 32'hFFFF_FFFF, s);
        count_low(n);
        tests_run++;
        if (n !== 0) begin tests_failed++; $display("FAIL other_addr: scan=%0d, required 0", n); end
        do_write(12'h3A2, 32'hFFFF_FFFF, s);
        count_low(n);
        tests_run++;
        if (n !== 0) begin tests_failed++; $display("FAIL cfg2_unimpl: scan=%0d, required 0", n); end
`ifdef PMP_CSR_READ_EN
        csr_bus.csr_addr_i = 12'h3B2;
        #1;
        tests_run++;
        if (csr_bus.csr_rdata_o !== 32'h0000_0FFF) begin
            tests_failed++; $display("FAIL read_addr2: %h, required 00000fff", csr_bus.csr_rdata_o);
        end
        csr_bus.csr_addr_i = 12'h3A0;
        #1;
        tests_run++;
        if (csr_bus.csr_rdata_o !== 32'h8800_8000) begin
            tests_failed++; $display("FAIL read_cfg0: %h, required 88008000", csr_bus.csr_rdata_o);
        end
        csr_bus.csr_addr_i = 12'h300;
        #1;
        tests_run++;
        if (csr_bus.csr_rdata_o !== 32'h0) begin
            tests_failed++; $display("FAIL read_other: %h, required 0", csr_bus.csr_rdata_o);
        end
        @(negedge clk);
`else
        csr_bus.csr_addr_i = 12'h3B2;
        #1;
        tests_run++;
        if (csr_bus.csr_rdata_o !== 32'h0) begin
            tests_failed++; $display("FAIL read_disabled: %h, required 0", csr_bus.csr_rdata_o);
        end
        @(negedge clk);
`endif
    endtask

    task automatic test_back_to_back();
        int s, n;
        do_write(12'h3A1, 32'h0000_0000, s);
        do_write(12'h3B0, 32'hC000_0007, s);
        tests_run++;
        if (s !== 4) begin tests_failed++; $display("FAIL b2b_stall: %0d cycles not ready, required 4", s); end
        count_low(n);
        tests_run++;
        if (n !== 1) begin tests_failed++; $display("FAIL b2b_scan: %0d, required 1", n); end
        tests_run++;
        if (base_of(0) !== 30'h0000_0007 || mask_of(0) !== 30'h3FFF_FFFF || mode_of(0) !== 2'd0) begin
            tests_failed++;
            $display("FAIL b2b_entry0: base=%h mask=%h mode=%h, required 7/3fffffff/0", base_of(0), mask_of(0), mode_of(0));
        end
    endtask

    task automatic test_reset_mid_scan();
        int s, n;
        do_write(12'h3A1, 32'h0000_0000, s);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (table_valid !== 1'b0 || csr_bus.csr_ready_o !== 1'b0 || entry_mode !== 16'h0 || entry_base !== 240'h0 || entry_perm !== 32'h0) begin
            tests_failed++;
            $display("FAIL midscan_reset_clear: valid=%b ready=%b mode=%h perm=%h, required all zero", table_valid, csr_bus.csr_ready_o, entry_mode, entry_perm);
        end
        rst = 1'b0;
        count_low(n);
        tests_run++;
        if (n !== 8) begin tests_failed++; $display("FAIL midscan_rescan: %0d, required 8", n); end
        tests_run++;
        if (mode_of(3) !== 2'd0 || perm_of(1) !== 4'h0 || base_of(2) !== 30'h0 || mask_of(2) !== 30'h3FFF_FFFF) begin
            tests_failed++;
            $display("FAIL midscan_table: mode3=%h perm1=%h base2=%h mask2=%h, required 0/0/0/3fffffff", mode_of(3), perm_of(1), base_of(2), mask_of(2));
        end
`ifdef PMP_CSR_READ_EN
        csr_bus.csr_addr_i = 12'h3B0;
        #1;
        tests_run++;
        if (csr_bus.csr_rdata_o !== 32'h0) begin
            tests_failed++; $display("FAIL midscan_read_addr0: %h, required 0", csr_bus.csr_rdata_o);
        end
        @(negedge clk);
`endif
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        test_reset();
        test_napot();
        test_lock_warl();
        test_tor_lock();
        test_back_to_back();
        test_reset_mid_scan();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
